xsimintf_change_capture: RTL and testbench
==========================================

// Module: xsimintf_change_capture
// PURPOSE
//  Upstream feeder of the xsim<->sydpy DPI co-simulation bridge. Samples a monitored DUT bus every
//  clk, detects value changes and timestamps each one with a free-running cycle count. Change records
//  are buffered and handed to the export stage over valid/ready, so the bridge exports only changes.
// PARAMETERS
//  DATA_W   32  width of monitored bus
//  TS_W     32  width of cycle timestamp (wraps)
//  DEPTH     8  record FIFO depth, power of 2, >=2
//  CNT_W    16  width of saturating stall counter
// PORTS
//  clk          in   1       clock; all logic on posedge
//  rst_n        in   1       reset; asynchronous assert, active-low
//  mon_data     in   DATA_W  monitored bus
//  mon_en       in   1       sample enable; 0 = ignore mon_data this cycle
//  rec_valid    out  1       record available at head of FIFO
//  rec_ready    in   1       export stage accepts head record
//  rec_data     out  DATA_W  captured value
//  rec_ts       out  TS_W    cycle count when the record was pushed
//  rec_ovf      out  1       1 = intermediate values lost before this record
//  stall_cnt    out  CNT_W   cycles a detected change waited on a full FIFO (saturating)
// BEHAVIOUR
//  Reset values: rec_valid=0, rec_data=0, rec_ts=0, rec_ovf=0, stall_cnt=0, ts=0, prev=0,
//   first=1, ovf_pend=0, FIFO empty. Reset during operation flushes all records.
//  Timestamp: ts increments by 1 every clk after reset release; wraps 2^TS_W-1 -> 0 without a flag.
//  Change detect (combinational, per cycle): chg = mon_en && (first || mon_data != prev).
//  Push: chg && (!full || pop). Simultaneous push and pop on a full FIFO is legal.
//   Record = {ts, mon_data, ovf_pend}. On push: prev<=mon_data, first<=0, ovf_pend<=0.
//  Blocked (chg && full && !pop): no push; prev NOT updated, so the change is re-detected and
//   retried each cycle; the timestamp is taken at the cycle of the actual push. ovf_pend<=1;
//   stall_cnt += 1, saturating at 2^CNT_W-1.
//  Lost values: if mon_data changes again while blocked, only the latest value is recorded, with
//   rec_ovf=1. The last stable value is therefore always delivered eventually.
//  First sample after reset always pushes (snapshot), even when mon_data==0.
//  mon_en=0: no detection; prev, first and ovf_pend hold; ts still counts.
//  Output: first-word-fall-through. rec_valid = !empty. rec_data, rec_ts and rec_ovf are the head
//   record and stay stable while rec_valid && !rec_ready. Pop = rec_valid && rec_ready.
//  Latency: change sampled at edge N into an empty FIFO -> rec_valid=1 after edge N, with
//   rec_ts = ts value at edge N. Throughput is 1 record/cycle.
//  Pop on an empty FIFO is a no-op. Push on a full FIFO without a simultaneous pop is never issued.
// STRUCTURE
//  xsimintf_pkg: TS_W/DATA_W defaults; function rec_w(d,t)=d+t+1 for the record width;
//   field-offset localparams for packing/unpacking {ts,data,ovf}.
//  Sub-module xsimintf_fifo: synchronous FWFT FIFO, params WIDTH/DEPTH; ports clk, rst_n, push,
//   wdata, pop, rdata, empty, full. Pointers are log2(DEPTH)+1 bits for full/empty detection.
//  Top level: ts counter, prev/first/ovf_pend registers, chg/push logic, stall counter, record pack.
// TESTING
//  1 Reset release, mon_en=1, mon_data=0 constant, rec_ready=1 -> exactly one record
//    {data=0, ts=0, ovf=0}, then no further records.
//  2 mon_data 0->0xFAFAFAFA at cycle 5, ->0x1 at cycle 6, rec_ready=1 -> records (ts=5, 0xFAFAFAFA)
//    and (ts=6, 0x1), each appearing one cycle after its sample, ovf=0.
//  3 rec_ready=0, DEPTH=8, change every cycle for 12 cycles -> 8 records held; stall_cnt=4;
//    rec_ready=1 -> 9th record carries the final value, ovf=1, and the earlier 8 carry ovf=0.
//  4 FIFO full, rec_ready=1 and a change in the same cycle -> pop and push both occur, count stays 8,
//    stall_cnt unchanged.
//  5 mon_en=0 while mon_data toggles, then mon_en=1 with value equal to prev -> no records; with
//    value !=prev -> one record.
//  6 rst_n low mid-stream with 5 queued -> rec_valid=0 asynchronously, ts=0; after release a new
//    snapshot record with ts=0.

Source files
------------

// File: rtl/xsimintf_pkg.sv
// Shared widths and record layout for the xsim change-capture feeder.
// A record is packed as {ts, data, ovf} with ovf in bit 0.
package xsimintf_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned TsWDef   = 32;

  localparam int unsigned OvfOff  = 0;
  localparam int unsigned DataOff = 1;

  function automatic int unsigned rec_w(input int unsigned d, input int unsigned t);
    return d + t + 1;
  endfunction

  function automatic int unsigned ts_off(input int unsigned d);
    return d + 1;
  endfunction

endpackage

// File: rtl/xsimintf_change_capture_if.sv
// Monitored-bus and record-stream signals of the change-capture feeder.
// master is the capture block (record producer), slave is the export side.
interface xsimintf_change_capture_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TS_W   = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [DATA_W-1:0] mon_data;
  logic              mon_en;
  logic              rec_valid;
  logic              rec_ready;
  logic [DATA_W-1:0] rec_data;
  logic [TS_W-1:0]   rec_ts;
  logic              rec_ovf;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  mon_data, mon_en, rec_ready,
    output rec_valid, rec_data, rec_ts, rec_ovf, stall_cnt
  );

  modport slave (
    output mon_data, mon_en, rec_ready,
    input  rec_valid, rec_data, rec_ts, rec_ovf, stall_cnt
  );
endinterface

// File: rtl/xsimintf_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata shows the head entry whenever !empty.
// Pointers carry one extra wrap bit to separate full from empty.
module xsimintf_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/xsimintf_change_capture.sv
// Samples a monitored bus, timestamps each value change and queues it for the DPI export stage.
// A change blocked by a full FIFO is retried every cycle, so the latest value always gets through.
module xsimintf_change_capture
  import xsimintf_pkg::*;
#(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned TS_W   = TsWDef,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input logic                           clk,
  input logic                           rst_n,
  xsimintf_change_capture_if.master     bus
);
  localparam int unsigned RecW  = rec_w(DATA_W, TS_W);
  localparam int unsigned TsOff = ts_off(DATA_W);

  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              first_q, first_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic              chg, push, pop, blocked;
  logic              empty, full;
  logic [RecW-1:0]   wrec, rrec;

  always_comb begin
    pop     = !empty && bus.rec_ready;
    chg     = bus.mon_en && (first_q || (bus.mon_data != prev_q));
    push    = chg && (!full || pop);
    blocked = chg && !push;
    wrec    = {ts_q, bus.mon_data, ovf_pend_q};

    ts_d       = ts_q + TS_W'(1);
    prev_d     = prev_q;
    first_d    = first_q;
    ovf_pend_d = ovf_pend_q;
    stall_d    = stall_q;
    if (push) begin
      prev_d     = bus.mon_data;
      first_d    = 1'b0;
      ovf_pend_d = 1'b0;
    end else if (blocked) begin
      // prev stays put so the pending change is re-detected next cycle.
      ovf_pend_d = 1'b1;
      if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      ovf_pend_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      ovf_pend_q <= ovf_pend_d;
      stall_q    <= stall_d;
    end
  end

  xsimintf_fifo #(
    .WIDTH (RecW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wrec),
    .pop   (pop),
    .rdata (rrec),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    bus.rec_valid = !empty;
    bus.rec_ovf   = rrec[OvfOff];
    bus.rec_data  = rrec[DataOff +: DATA_W];
    bus.rec_ts    = rrec[TsOff +: TS_W];
    bus.stall_cnt = stall_q;
  end

endmodule

// File: tb/tb_xsimintf_change_capture.sv
// Self-checking bench for xsimintf_change_capture: directed scenarios plus a randomized run
// compared against a queue-based reference model of the capture rules.
module tb_xsimintf_change_capture;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TS_W   = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CMAX   = 15;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
    logic              ovf;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xsimintf_change_capture_if #(.DATA_W(DATA_W), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

  xsimintf_change_capture #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  rec_t              mq[$];
  logic [TS_W-1:0]   m_ts;
  logic [DATA_W-1:0] m_prev;
  bit                m_first;
  bit                m_pend;
  int                m_stall;

  function automatic logic [41:0] pk(input logic v, input logic [31:0] d, input logic [7:0] t,
                                     input logic o);
    return {v, d, t, o};
  endfunction

  function automatic logic [41:0] obs();
    return {bus.rec_valid, bus.rec_data, bus.rec_ts, bus.rec_ovf};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ts = '0; m_prev = '0; m_first = 1'b1; m_pend = 1'b0; m_stall = 0;
  endtask

  // Advance the model by one clock using the current inputs, then let the DUT take the edge.
  task automatic cycle();
    bit   pop, chg, push;
    rec_t r;
    pop  = (mq.size() != 0) && bus.rec_ready;
    chg  = bus.mon_en && (m_first || (bus.mon_data != m_prev));
    push = chg && ((mq.size() < DEPTH) || pop);
    if (pop) void'(mq.pop_front());
    if (push) begin
      r.data = bus.mon_data; r.ts = m_ts; r.ovf = m_pend;
      mq.push_back(r);
      m_prev = bus.mon_data; m_first = 1'b0; m_pend = 1'b0;
    end else if (chg) begin
      m_pend = 1'b1;
      if (m_stall < CMAX) m_stall++;
    end
    m_ts = m_ts + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.mon_en = 1'b1; bus.mon_data = '0; bus.rec_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if (obs() !== pk(1'b0, 32'h0, 8'h0, 1'b0)) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs(), pk(1'b0, 32'h0, 8'h0, 1'b0));
    end
    n_vec++;
    if (bus.stall_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt);
    end
  endtask

  task automatic test_snapshot();
    do_reset();
    bus.mon_en = 1'b1; bus.mon_data = '0; bus.rec_ready = 1'b1;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'h0, 8'h0, 1'b0)) begin
      n_err++; $display("FAIL snap_rec: got %h want %h", obs(), pk(1'b1, 32'h0, 8'h0, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_vec++;
      if (bus.rec_valid !== 1'b0) begin
        n_err++; $display("FAIL snap_quiet: cycle %0d valid got %b want 0", i, bus.rec_valid);
      end
    end
  endtask

  task automatic test_change();
    do_reset();
    bus.mon_en = 1'b1; bus.mon_data = '0; bus.rec_ready = 1'b1;
    repeat (5) cycle();
    n_vec++;
    if (bus.rec_valid !== 1'b0) begin
      n_err++; $display("FAIL chg_idle: valid got %b want 0", bus.rec_valid);
    end
    bus.mon_data = 32'hFAFA_FAFA;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'hFAFA_FAFA, 8'd5, 1'b0)) begin
      n_err++; $display("FAIL chg_rec1: got %h want %h", obs(), pk(1'b1, 32'hFAFA_FAFA, 8'd5, 1'b0));
    end
    bus.mon_data = 32'h1;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'h1, 8'd6, 1'b0)) begin
      n_err++; $display("FAIL chg_rec2: got %h want %h", obs(), pk(1'b1, 32'h1, 8'd6, 1'b0));
    end
    cycle();
    n_vec++;
    if (bus.rec_valid !== 1'b0) begin
      n_err++; $display("FAIL chg_drained: valid got %b want 0", bus.rec_valid);
    end
  endtask

  task automatic test_overflow();
    logic [41:0] exp;
    do_reset();
    bus.mon_en = 1'b1; bus.rec_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.mon_data = 32'(i + 1);
      cycle();
    end
    n_vec++;
    if (bus.stall_cnt !== 4'd4) begin
      n_err++; $display("FAIL ovf_stall: got %0d want 4", bus.stall_cnt);
    end
    bus.rec_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      exp = (k < 8) ? pk(1'b1, 32'(k + 1), 8'(k), 1'b0) : pk(1'b1, 32'd12, 8'd12, 1'b1);
      n_vec++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL ovf_rec%0d: got %h want %h", k, obs(), exp);
      end
      cycle();
    end
    n_vec++;
    if (bus.rec_valid !== 1'b0 || bus.stall_cnt !== 4'd4) begin
      n_err++; $display("FAIL ovf_end: valid %b stall %0d want 0/4", bus.rec_valid, bus.stall_cnt);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    bus.mon_en = 1'b1; bus.rec_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.mon_data = 32'h100 + 32'(i);
      cycle();
    end
    bus.rec_ready = 1'b1; bus.mon_data = 32'h200;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'h101, 8'd1, 1'b0) || bus.stall_cnt !== 4'd0) begin
      n_err++; $display("FAIL full_pp: got %h stall %0d want %h stall 0", obs(), bus.stall_cnt,
                        pk(1'b1, 32'h101, 8'd1, 1'b0));
    end
    bus.rec_ready = 1'b0; bus.mon_data = 32'h201;
    cycle();
    n_vec++;
    if (bus.stall_cnt !== 4'd1) begin
      n_err++; $display("FAIL full_still8: stall got %0d want 1", bus.stall_cnt);
    end
    bus.rec_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      n_vec++;
      if (mq.size() == 0 ? (bus.rec_valid !== 1'b0) :
          (obs() !== pk(1'b1, mq[0].data, mq[0].ts, mq[0].ovf))) begin
        n_err++; $display("FAIL full_drain%0d: got %h", k, obs());
      end
    end
  endtask

  task automatic test_mon_en();
    do_reset();
    bus.mon_en = 1'b1; bus.mon_data = 32'h55; bus.rec_ready = 1'b1;
    cycle();
    cycle();
    bus.mon_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.mon_data = $urandom;
      cycle();
      n_vec++;
      if (bus.rec_valid !== 1'b0) begin
        n_err++; $display("FAIL en_off%0d: valid got %b want 0", i, bus.rec_valid);
      end
    end
    bus.mon_en = 1'b1; bus.mon_data = 32'h55;
    repeat (2) cycle();
    n_vec++;
    if (bus.rec_valid !== 1'b0) begin
      n_err++; $display("FAIL en_same: valid got %b want 0", bus.rec_valid);
    end
    bus.mon_data = 32'h66;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'h66, 8'd10, 1'b0)) begin
      n_err++; $display("FAIL en_new: got %h want %h", obs(), pk(1'b1, 32'h66, 8'd10, 1'b0));
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    bus.mon_en = 1'b1; bus.rec_ready = 1'b0;
    for (int i = 0; i < 28; i++) begin
      bus.mon_data = 32'(i + 1);
      cycle();
    end
    n_vec++;
    if (bus.stall_cnt !== 4'd15) begin
      n_err++; $display("FAIL stall_sat: got %0d want 15", bus.stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.mon_en = 1'b1; bus.rec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mon_data = 32'(i + 1);
      cycle();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (obs() !== pk(1'b0, 32'h0, 8'h0, 1'b0)) begin
      n_err++; $display("FAIL arst_flush: got %h want %h", obs(), pk(1'b0, 32'h0, 8'h0, 1'b0));
    end
    model_reset();
    bus.mon_data = 32'h77; bus.rec_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_vec++;
    if (obs() !== pk(1'b1, 32'h77, 8'h0, 1'b0)) begin
      n_err++; $display("FAIL arst_snap: got %h want %h", obs(), pk(1'b1, 32'h77, 8'h0, 1'b0));
    end
  endtask

  task automatic test_random();
    int rdy_div;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdy_div = (i < 300) ? 4 : 2;
      bus.mon_en    = ($urandom % 4) != 0;
      bus.mon_data  = 32'($urandom % 4);
      bus.rec_ready = ($urandom % rdy_div) == 0;
      cycle();
      n_vec++;
      if (bus.rec_valid !== (mq.size() != 0)) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.rec_valid, mq.size() != 0);
      end else if (mq.size() != 0) begin
        n_vec++;
        if (obs() !== pk(1'b1, mq[0].data, mq[0].ts, mq[0].ovf)) begin
          n_err++; $display("FAIL rnd_head@%0d: got %h want %h", i, obs(),
                            pk(1'b1, mq[0].data, mq[0].ts, mq[0].ovf));
        end
      end
      n_vec++;
      if (bus.stall_cnt !== CNT_W'(m_stall)) begin
        n_err++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, bus.stall_cnt, m_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_change();
    test_overflow();
    test_full_pushpop();
    test_mon_en();
    test_stall_sat();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
